// File: rtl/id_ex_dump_tx_if.sv
// id_ex_dump_tx_if: dump request/status and byte-wide UART TX handshake
interface id_ex_dump_tx_if #(parameter int NB_BYTE = 8);
  logic               i_dump_req;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_busy;
  logic               o_dump_done;
  modport master(input i_dump_req, i_tx_done, output o_tx_start, o_tx_data, o_busy, o_dump_done);
  modport slave(output i_dump_req, i_tx_done, input o_tx_start, o_tx_data, o_busy, o_dump_done);
endinterface

// File: rtl/id_ex_dump_tx.sv
// id_ex_dump_tx: snapshots the ID/EX debug word and streams it LSB byte first to the UART TX
module id_ex_dump_tx #(
  parameter int ID_EX_SIZE = 147,
  parameter int NB_BYTE    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ID_EX_SIZE-1:0] i_ID_EX_data,
  id_ex_dump_tx_if.master       bus
);
  localparam int N_BYTES = (ID_EX_SIZE + NB_BYTE - 1) / NB_BYTE;
  localparam int NB_CNT  = $clog2(N_BYTES);
  localparam int NB_SH   = N_BYTES * NB_BYTE;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t            state, next;
  logic [NB_SH-1:0]  shreg;
  logic [NB_CNT-1:0] cnt;
  logic              last;
  assign last = cnt == NB_CNT'(N_BYTES - 1);
  always_comb begin
    next = state;
    next = state == IDLE ? (bus.i_dump_req ? SEND : IDLE) :
           state == SEND ? WAIT :
           state == WAIT ? (bus.i_tx_done ? (last ? DONE : SEND) : WAIT) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= next;
      if (state == IDLE && bus.i_dump_req) begin
        shreg <= NB_SH'(i_ID_EX_data);
        cnt   <= '0;
      end else if (state == WAIT && bus.i_tx_done) begin
        shreg <= shreg >> NB_BYTE;
        if (!last) cnt <= cnt + NB_CNT'(1);
      end
    end
  end
  assign bus.o_tx_start  = state == SEND;
  assign bus.o_tx_data   = shreg[NB_BYTE-1:0];
  assign bus.o_busy      = state != IDLE;
  assign bus.o_dump_done = state == DONE;
endmodule

// File: tb/tb_id_ex_dump_tx.sv
// tb_id_ex_dump_tx: scoreboard bench for the ID/EX dump byte streamer
`timescale 1ns/1ps
module tb_id_ex_dump_tx;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [146:0] data = '0;
  logic [7:0]   sb[$];
  logic [7:0]   cur = '0;
  int           checks = 0;
  int           failures = 0;
  int           n_starts = 0;
  int           n_done = 0;
  id_ex_dump_tx_if #(.NB_BYTE(8)) bus();
  id_ex_dump_tx dut (.i_clk(clk), .i_reset(rst), .i_ID_EX_data(data), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.o_tx_start) begin
      n_starts++;
      cur = bus.o_tx_data;
      if (sb.size() == 0) chk("extra_byte", 64'd1, 64'd0);
      else chk("byte", 64'(bus.o_tx_data), 64'(sb.pop_front()));
    end else if (bus.o_busy && !bus.o_dump_done && !rst) begin
      chk("stable", 64'(bus.o_tx_data), 64'(cur));
    end
    if (bus.o_dump_done) n_done++;
  end
  task automatic wait_start();
    int t = 0;
    while (!bus.o_tx_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", 64'(bus.o_tx_start), 64'd1);
  endtask
  task automatic run_dump(input logic [146:0] d, input int lat, input bit chg, input bit poke, input int abort_at);
    logic [151:0] img;
    time t0;
    int n0;
    img = {5'b0, d};
    data = d;
    n_starts = 0;
    n0 = n_done;
    for (int k = 0; k < 19; k++) sb.push_back(img[8*k +: 8]);
    bus.i_dump_req = 1'b1;
    @(negedge clk);
    bus.i_dump_req = 1'b0;
    t0 = $time;
    chk("req_start", 64'({bus.o_tx_start, bus.o_busy}), 64'd3);
    for (int k = 0; k < 19; k++) begin
      wait_start();
      if (!bus.o_tx_start) return;
      if (chg && k == 0) data = '0;
      if (poke && k == 3) bus.i_tx_done = 1'b1;
      @(negedge clk);
      bus.i_tx_done = 1'b0;
      if (poke && k == 3) bus.i_dump_req = 1'b1;
      for (int w = 1; w < lat; w++) begin
        @(negedge clk);
        bus.i_dump_req = 1'b0;
        chk("busy_wait", 64'(bus.o_busy), 64'd1);
      end
      bus.i_tx_done = 1'b1;
      @(negedge clk);
      bus.i_tx_done = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", 64'({bus.o_tx_start, bus.o_busy, bus.o_dump_done, bus.o_tx_data}), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(n_done), 64'(n0));
        chk("abort_idle", 64'(bus.o_busy), 64'd0);
        return;
      end
    end
    chk("dump_done", 64'(bus.o_dump_done), 64'd1);
    if (lat == 1) chk("dump_len", 64'(($time - t0) / 10), 64'd38);
    @(negedge clk);
    chk("busy_clear", 64'(bus.o_busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("no_restart", 64'(bus.o_busy), 64'd0);
    chk("n_bytes", 64'(n_starts), 64'd19);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    bus.i_dump_req = 1'b0;
    bus.i_tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({bus.o_tx_start, bus.o_busy, bus.o_dump_done}), 64'd0);
    chk("rst_data", 64'(bus.o_tx_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    chk("idle_ignores_done", 64'(bus.o_busy), 64'd0);
    run_dump(147'h1, 1, 1'b0, 1'b0, -1);
    run_dump({147{1'b1}}, 1, 1'b0, 1'b0, -1);
    run_dump(147'h1 << 146, 1, 1'b0, 1'b0, -1);
    run_dump({$urandom, $urandom, $urandom, $urandom, $urandom}, 1, 1'b1, 1'b0, -1);
    run_dump({$urandom, $urandom, $urandom, $urandom, $urandom}, 3, 1'b0, 1'b1, -1);
    run_dump({$urandom, $urandom, $urandom, $urandom, $urandom}, 10, 1'b0, 1'b0, -1);
    run_dump({$urandom, $urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 1'b0, 5);
    run_dump({$urandom, $urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_dump_tx.md
# id_ex_dump_tx

Debug-side reader for the ID/EX pipeline latch's packed debug word. On request it snapshots the 147-bit latch image and streams it, one byte at a time, to the UART transmitter over a start/done byte handshake. It sits between the ID/EX latch's debug output and the debug unit's UART TX. It lets the host read the ID/EX stage contents after a step or at end of program.

## Interface
Parameters:
- `ID_EX_SIZE`, default 147: width of the packed latch word.
- `NB_BYTE`, default 8: width of one transmitted byte.
- Derived, not overridable: `N_BYTES` = ceil(`ID_EX_SIZE`/`NB_BYTE`) = 19. `NB_CNT` = clog2(`N_BYTES`) = 5.

Ports:
- `i_clk`  in  1  system clock; all state changes on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_ID_EX_data`  in  `ID_EX_SIZE`  packed ID/EX latch image.
  - Bit 0 is WB, bit 1 is M, bit 2 is EX.
  - Bits [8:3] are PC, [40:9] are rs1 data, [72:41] are rs2 data, [136:73] are the immediate.
  - Bits [140:137] are funct bits, [145:141] are rd, bit 146 is EOF.
- `i_dump_req`  in  1  start a dump. Sampled only in IDLE.
- `i_tx_done`  in  1  UART TX finished the current byte. One-cycle pulse, sampled only in WAIT.
- `o_tx_start`  out  1  high for exactly one cycle per byte; the UART TX loads `o_tx_data` in that cycle.
- `o_tx_data`  out  `NB_BYTE`  current byte. Stable from its `o_tx_start` cycle until the matching `i_tx_done` is accepted.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_dump_done`  out  1  one-cycle pulse after the last byte is acknowledged.

## Operation
- State machine: IDLE, SEND, WAIT, DONE.
- Internal registers:
  - Shift register `shreg`, `N_BYTES*NB_BYTE` = 152 bits.
  - Byte counter `cnt`, `NB_CNT` bits.
- IDLE: when `i_dump_req`=1, load `shreg` <= {5'b0, `i_ID_EX_data`}, set `cnt` <= 0, go to SEND. Otherwise stay in IDLE.
- SEND: go unconditionally to WAIT.
- WAIT, with `i_tx_done`=1:
  - Shift `shreg` right by `NB_BYTE`, filling with zeros.
  - If `cnt` == `N_BYTES`-1, go to DONE. Otherwise `cnt` <= `cnt`+1 and go to SEND.
- WAIT, with `i_tx_done`=0: hold state, `shreg` and `cnt`.
- DONE: go unconditionally to IDLE.
- Outputs, all combinational from registered state:
  - `o_tx_start` = (state == SEND).
  - `o_tx_data` = `shreg`[7:0].
  - `o_busy` = (state != IDLE).
  - `o_dump_done` = (state == DONE).
- Byte order: byte k carries `i_ID_EX_data`[8k+7:8k], LSB first.
  - Byte 18 carries bits [146:144] in its bits [2:0]; its bits [7:3] are always 0.
  - EOF therefore appears as bit 2 of byte 18.
- The snapshot is taken only at the IDLE→SEND edge. Later changes on `i_ID_EX_data` do not affect a dump in progress.
- `i_dump_req` is ignored in SEND, WAIT and DONE; it is not queued.
- `i_tx_done` is ignored outside WAIT.
- Reset values: state IDLE, `shreg` 0, `cnt` 0. Hence `o_tx_start`=0, `o_tx_data`=8'h00, `o_busy`=0, `o_dump_done`=0.
- Reset mid-dump aborts the dump at the next edge. No further bytes are sent and no `o_dump_done` pulse is generated.
- Reset has priority over every other input.

## Timing
- `i_dump_req` sampled at edge t → in cycle t+1: `o_tx_start`=1, `o_tx_data`=byte 0, `o_busy`=1.
- Per byte: one SEND cycle, then at least one WAIT cycle. A byte acknowledged at edge m has its successor's `o_tx_start` in cycle m+1.
- Minimum dump length is 2·19 + 1 = 39 cycles from the first `o_tx_start` to `o_dump_done`. This minimum applies when every `i_tx_done` arrives in the first WAIT cycle.
- Last acknowledge at edge m → `o_dump_done`=1 in cycle m+1 → `o_busy`=0 in cycle m+2.
- A new `i_dump_req` can be accepted from cycle m+2 onward.

## Test plan
- `i_ID_EX_data`=147'h1, `i_dump_req` pulse, `i_tx_done` returned 1 cycle after each `o_tx_start`:
  - Required: 19 `o_tx_start` pulses; bytes 01, then 00 ×18.
  - Required: `o_dump_done` 1 cycle after the last ack; total 39 cycles.
- All-ones input:
  - Required: bytes FF ×18, then 07.
  - With only bit 146 set (EOF): bytes 00 ×18, then 04.
- `i_ID_EX_data` changed to 0 after the first `o_tx_start`:
  - Required: the transmitted stream still matches the snapshot.
- `i_dump_req` pulsed during WAIT of byte 3, and `i_tx_done` pulsed during SEND:
  - Required: both are ignored; byte count remains 19; no second dump starts.
- Slow UART, `i_tx_done` 10 cycles after each start:
  - Required: `o_tx_data` is stable for all WAIT cycles and `o_busy` stays high throughout.
- Assert `i_reset` after byte 5 is acknowledged:
  - Required: next cycle state is IDLE and all outputs are 0; no `o_dump_done`.
  - Required: a new request afterwards restarts from byte 0.
